// File: rtl/ovi_seq_pkg.sv
// Shared types and default sizes for the OVI issue sequencer and its sb-id queue.
package ovi_seq_pkg;

    localparam int SB_WIDTH_DEF    = 5;
    localparam int MAX_CREDITS_DEF = 4;
    localparam int QUEUE_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } seq_state_e;

    // One in-flight queue entry at the default id width.
    typedef logic [SB_WIDTH_DEF-1:0] sb_entry_t;

endpackage

// File: rtl/ovi_sb_queue.sv
// Circular sb-id buffer with three pointers: head (oldest not completed),
// disp (oldest undispatched) and wr (next free slot).
module ovi_sb_queue
    import ovi_seq_pkg::*;
#(
    parameter int SB_WIDTH = SB_WIDTH_DEF,
    parameter int DEPTH    = QUEUE_DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH),
    localparam int PW      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [SB_WIDTH-1:0] push_sb,
    input  logic                advance,
    input  logic                flush,
    input  logic                pop,
    output logic [SB_WIDTH-1:0] head_sb,
    output logic [SB_WIDTH-1:0] disp_sb,
    output logic                full,
    output logic                has_undisp,
    output logic                has_disp,
    output logic [PW-1:0]       count,
    output logic [PW-1:0]       count_next
);

    logic [PW-1:0]       head;
    logic [PW-1:0]       disp;
    logic [PW-1:0]       wr;
    logic [PW-1:0]       head_n;
    logic [PW-1:0]       disp_n;
    logic [PW-1:0]       wr_n;
    logic [SB_WIDTH-1:0] mem [DEPTH];

    // A flush rewinds wr to disp and drops any push in the same cycle.
    always_comb begin
        head_n = head;
        disp_n = disp;
        wr_n   = wr;
        if (pop) begin
            head_n = head + PW'(1);
        end
        if (advance) begin
            disp_n = disp + PW'(1);
        end
        if (flush) begin
            wr_n = disp;
        end else if (push) begin
            wr_n = wr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            disp <= '0;
            wr   <= '0;
        end else begin
            head <= head_n;
            disp <= disp_n;
            wr   <= wr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr[AW-1:0]] <= push_sb;
        end
    end

    assign head_sb    = mem[head[AW-1:0]];
    assign disp_sb    = mem[disp[AW-1:0]];
    assign count      = wr - head;
    assign count_next = wr_n - head_n;
    assign full       = (count == PW'(DEPTH));
    assign has_undisp = (disp != wr);
    assign has_disp   = (head != disp);

endmodule

// File: rtl/ovi_issue_sequencer.sv
// Credit-gated OVI issue front end: tracks in-flight sb ids, turns core commit/kill
// decisions into dispatch pulses, retires on completion and supports drain.
module ovi_issue_sequencer
    import ovi_seq_pkg::*;
#(
    parameter int SB_WIDTH    = SB_WIDTH_DEF,
    parameter int INSTR_WIDTH = 32,
    parameter int CSR_WIDTH   = 40,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_CREDITS = MAX_CREDITS_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    localparam int IW         = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [INSTR_WIDTH-1:0] req_instr_i,
    input  logic [SB_WIDTH-1:0]    req_sb_id_i,
    input  logic [CSR_WIDTH-1:0]   req_csr_i,
    input  logic [DATA_WIDTH-1:0]  req_data_i,
    input  logic                   commit_valid_i,
    input  logic                   commit_kill_i,
    input  logic                   drain_i,
    output logic                   drained_o,
    output logic                   issue_valid_o,
    output logic [INSTR_WIDTH-1:0] issue_instr_o,
    output logic [SB_WIDTH-1:0]    issue_sb_id_o,
    output logic [CSR_WIDTH-1:0]   issue_csr_o,
    output logic [DATA_WIDTH-1:0]  issue_data_o,
    input  logic                   issue_credit_i,
    output logic                   dispatch_nxt_sen_o,
    output logic                   dispatch_kill_o,
    output logic [SB_WIDTH-1:0]    dispatch_sb_id_o,
    input  logic                   completed_valid_i,
    input  logic [SB_WIDTH-1:0]    completed_sb_id_i,
    output logic [IW-1:0]          inflight_o,
    output logic                   seq_err_o
);

    localparam int CW = $clog2(MAX_CREDITS + 1);

    seq_state_e          state;
    seq_state_e          state_n;
    logic [CW-1:0]       credits;
    logic                ready_en;
    logic                pending_kill;
    logic [SB_WIDTH-1:0] pending_sb;

    logic                accept;
    logic                commit_ok;
    logic                do_adv;
    logic                do_kill;
    logic                pop_ok;
    logic                any_err;
    logic [SB_WIDTH-1:0] head_sb;
    logic [SB_WIDTH-1:0] disp_sb;
    logic                q_full;
    logic                has_undisp;
    logic                has_disp;
    logic [IW-1:0]       q_count;
    logic [IW-1:0]       q_count_next;

    // ready_en keeps req_ready_o low while in reset and on the first cycle out of it.
    assign req_ready_o = ready_en && (state == RUN) && (credits != '0) && !q_full;
    assign accept      = req_valid_i && req_ready_o;
    assign commit_ok   = commit_valid_i && has_undisp;
    assign do_adv      = commit_ok && !commit_kill_i;
    assign do_kill     = commit_ok && commit_kill_i;
    assign pop_ok      = completed_valid_i && has_disp && (completed_sb_id_i == head_sb);
    assign any_err     = (commit_valid_i && !has_undisp)
                       || (completed_valid_i && !pop_ok)
                       || (issue_credit_i && !accept && (credits == CW'(MAX_CREDITS)));

    ovi_sb_queue #(
        .SB_WIDTH (SB_WIDTH),
        .DEPTH    (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk_i),
        .rst_n      (rsn_i),
        .push       (accept),
        .push_sb    (req_sb_id_i),
        .advance    (do_adv),
        .flush      (do_kill),
        .pop        (pop_ok),
        .head_sb    (head_sb),
        .disp_sb    (disp_sb),
        .full       (q_full),
        .has_undisp (has_undisp),
        .has_disp   (has_disp),
        .count      (q_count),
        .count_next (q_count_next)
    );

    assign inflight_o = q_count;
    assign drained_o  = (state == DRAINED);

    always_comb begin
        state_n = state;
        case (state)
            RUN: begin
                if (drain_i) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if ((q_count_next == '0) && !(do_kill && accept)) begin
                    state_n = DRAINED;
                end
            end
            DRAINED: begin
                if (!drain_i) begin
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state    <= RUN;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            ready_en <= 1'b1;
        end
    end

    // A credit arriving at the ceiling with no accept is a VPU protocol error; hold the count.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            credits <= CW'(MAX_CREDITS);
        end else if (accept && !issue_credit_i) begin
            credits <= credits - CW'(1);
        end else if (!accept && issue_credit_i && (credits != CW'(MAX_CREDITS))) begin
            credits <= credits + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            seq_err_o <= 1'b0;
        end else if (any_err) begin
            seq_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            issue_valid_o <= 1'b0;
            issue_instr_o <= '0;
            issue_sb_id_o <= '0;
            issue_csr_o   <= '0;
            issue_data_o  <= '0;
        end else begin
            issue_valid_o <= accept;
            if (accept) begin
                issue_instr_o <= req_instr_i;
                issue_sb_id_o <= req_sb_id_i;
                issue_csr_o   <= req_csr_i;
                issue_data_o  <= req_data_i;
            end
        end
    end

    // An instruction accepted alongside a kill is issued but flushed; its kill pulse
    // follows one cycle after the main kill pulse.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            pending_kill       <= 1'b0;
            pending_sb         <= '0;
            dispatch_nxt_sen_o <= 1'b0;
            dispatch_kill_o    <= 1'b0;
            dispatch_sb_id_o   <= '0;
        end else begin
            pending_kill       <= do_kill && accept;
            pending_sb         <= req_sb_id_i;
            dispatch_nxt_sen_o <= do_adv;
            dispatch_kill_o    <= do_kill || pending_kill;
            if (commit_ok) begin
                dispatch_sb_id_o <= disp_sb;
            end else if (pending_kill) begin
                dispatch_sb_id_o <= pending_sb;
            end else begin
                dispatch_sb_id_o <= '0;
            end
        end
    end

endmodule
